// File: rtl/bp_mem_traffic_gen_pkg.sv
// Shared types for the memory traffic generator: BedRock cce mem message layout,
// size encodings and the generator FSM states.
package bp_mem_traffic_gen_pkg;

  localparam int paddr_width_p       = 40;
  localparam int cce_block_width_p   = 512;
  localparam int mem_payload_width_p = 16;
  localparam int block_offset_lp     = $clog2(cce_block_width_p/8);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [mem_payload_width_p-1:0] payload;
    bp_bedrock_msg_size_e           size;
    logic [paddr_width_p-1:0]       addr;
    bp_bedrock_mem_type_e           msg_type;
  } bp_bedrock_cce_mem_header_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_bedrock_cce_mem_header_s   header;
  } bp_bedrock_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_bedrock_cce_mem_msg_s);

  typedef enum logic [2:0] {
    e_tg_idle,
    e_tg_write,
    e_tg_wr_drain,
    e_tg_read,
    e_tg_rd_drain,
    e_tg_done
  } bp_mem_traffic_gen_state_e;

  function automatic bp_bedrock_msg_size_e msg_size_for(input int bytes);
    case (bytes)
      1:       return e_bedrock_msg_size_1;
      2:       return e_bedrock_msg_size_2;
      4:       return e_bedrock_msg_size_4;
      8:       return e_bedrock_msg_size_8;
      16:      return e_bedrock_msg_size_16;
      32:      return e_bedrock_msg_size_32;
      128:     return e_bedrock_msg_size_128;
      default: return e_bedrock_msg_size_64;
    endcase
  endfunction

  localparam bp_bedrock_msg_size_e block_size_lp = msg_size_for(cce_block_width_p/8);

endpackage

// File: rtl/bp_mem_traffic_gen_pattern.sv
// Combinational test pattern: the word {seed, index[15:0]} replicated across a cache block.
module bp_mem_traffic_pattern
  import bp_mem_traffic_gen_pkg::*;
#(
  parameter int idx_width_p = 5
)(
  input  logic [15:0]                  seed_i,
  input  logic [idx_width_p-1:0]       index_i,
  output logic [cce_block_width_p-1:0] data_o
);

  logic [15:0] index16;

  assign index16 = 16'(index_i);
  assign data_o  = {(cce_block_width_p/32){seed_i, index16}};

endmodule

// File: rtl/bp_mem_traffic_gen.sv
// Self-checking memory exerciser: writes a seeded pattern over a block range, reads it back
// and counts mismatches. Define BP_MEM_TRAFFIC_GEN_TRACE_EN for a per-message simulation trace.
module bp_mem_traffic_gen
  import bp_mem_traffic_gen_pkg::*;
#(
  parameter logic [paddr_width_p-1:0] base_addr_p       = '0,
  parameter int                       num_blocks_p      = 16,
  parameter int                       max_outstanding_p = 4,
  parameter int                       err_width_p       = 16
)(
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic [15:0]                     seed_i,
  output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [err_width_p-1:0]          error_count_o
);

  localparam int cntWidth = $clog2(num_blocks_p+1);
  localparam int outWidth = $clog2(max_outstanding_p+1);
  localparam logic [cntWidth-1:0] numBlocks      = cntWidth'(num_blocks_p);
  localparam logic [outWidth-1:0] maxOutstanding = outWidth'(max_outstanding_p);

  bp_mem_traffic_gen_state_e state_q, state_d;
  logic [cntWidth-1:0]    issueCnt_q, issueCnt_d, respCnt_q, respCnt_d;
  logic [outWidth-1:0]    outstanding_q, outstanding_d;
  logic [15:0]            seed_q, seed_d;
  logic [err_width_p-1:0] errCnt_q, errCnt_d;

  logic startAccept, issuePhase, writeResp, readResp;
  logic respSpurious, respLegal, respMismatch, errInc;
  logic unusedRespBits;
  logic [cce_block_width_p-1:0] issuePattern, checkPattern;
  bp_bedrock_cce_mem_msg_s cmdMsg, respMsg;
  bp_bedrock_mem_type_e    expRespType;

  function automatic logic [paddr_width_p-1:0] blockAddr(input logic [cntWidth-1:0] idx);
    return base_addr_p + (paddr_width_p'(idx) << block_offset_lp);
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_tg_idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_tg_idle:     if (start_i)                state_d = e_tg_write;
      e_tg_write:    if (issueCnt_q == numBlocks) state_d = e_tg_wr_drain;
      e_tg_wr_drain: if (respCnt_q == numBlocks)  state_d = e_tg_read;
      e_tg_read:     if (issueCnt_q == numBlocks) state_d = e_tg_rd_drain;
      e_tg_rd_drain: if (respCnt_q == numBlocks)  state_d = e_tg_done;
      e_tg_done:     if (start_i)                state_d = e_tg_write;
      default:                                   state_d = e_tg_idle;
    endcase
  end

  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    issuePhase = 1'b0;
    writeResp  = 1'b0;
    readResp   = 1'b0;
    unique case (state_q)
      e_tg_write:    begin busy_o = 1'b1; issuePhase = 1'b1; writeResp = 1'b1; end
      e_tg_wr_drain: begin busy_o = 1'b1; writeResp = 1'b1; end
      e_tg_read:     begin busy_o = 1'b1; issuePhase = 1'b1; readResp = 1'b1; end
      e_tg_rd_drain: begin busy_o = 1'b1; readResp = 1'b1; end
      e_tg_done:     done_o = 1'b1;
      default:       ;
    endcase
    // Valid only ever rises alongside ready, so every valid cycle is an accepted command
    mem_cmd_v_o = issuePhase & (issueCnt_q < numBlocks)
                & (outstanding_q < maxOutstanding) & mem_cmd_ready_i;
  end

  assign startAccept     = start_i & ((state_q == e_tg_idle) | (state_q == e_tg_done));
  assign mem_resp_yumi_o = mem_resp_v_i;
  assign respMsg         = mem_resp_i;
  assign unusedRespBits  = ^{respMsg.header.payload, respMsg.header.size};

  assign respSpurious = ~(writeResp | readResp) | (respCnt_q == numBlocks);
  assign respLegal    = mem_resp_v_i & ~respSpurious;
  assign expRespType  = writeResp ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
  assign respMismatch = (respMsg.header.addr != blockAddr(respCnt_q))
                      | (respMsg.header.msg_type != expRespType)
                      | (readResp & (respMsg.data != checkPattern));
  assign errInc       = mem_resp_v_i & (respSpurious | respMismatch);

  bp_mem_traffic_pattern #(.idx_width_p(cntWidth)) issuePat (
    .seed_i (seed_q),
    .index_i(issueCnt_q),
    .data_o (issuePattern)
  );

  bp_mem_traffic_pattern #(.idx_width_p(cntWidth)) checkPat (
    .seed_i (seed_q),
    .index_i(respCnt_q),
    .data_o (checkPattern)
  );

  always_comb begin
    cmdMsg                 = '0;
    cmdMsg.header.msg_type = (state_q == e_tg_read) ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr;
    cmdMsg.header.addr     = blockAddr(issueCnt_q);
    cmdMsg.header.size     = block_size_lp;
    cmdMsg.header.payload  = '0;
    cmdMsg.data            = (state_q == e_tg_write) ? issuePattern : '0;
  end

  assign mem_cmd_o = cmdMsg;

  always_comb begin
    issueCnt_d    = issueCnt_q;
    respCnt_d     = respCnt_q;
    outstanding_d = outstanding_q;
    seed_d        = seed_q;
    errCnt_d      = errCnt_q;
    if (startAccept) begin
      issueCnt_d    = '0;
      respCnt_d     = '0;
      outstanding_d = '0;
      errCnt_d      = '0;
      seed_d        = seed_i;
    end else begin
      // Write-to-read turnaround restarts both counters so the read pass reuses block indices
      if ((state_q == e_tg_wr_drain) && (respCnt_q == numBlocks)) begin
        issueCnt_d = '0;
        respCnt_d  = '0;
      end else begin
        if (mem_cmd_v_o) issueCnt_d = issueCnt_q + 1'b1;
        if (respLegal)   respCnt_d  = respCnt_q + 1'b1;
      end
      if (mem_cmd_v_o && !respLegal)
        outstanding_d = outstanding_q + 1'b1;
      else if (!mem_cmd_v_o && respLegal && (outstanding_q != '0))
        outstanding_d = outstanding_q - 1'b1;
      if (errInc && !(&errCnt_q)) errCnt_d = errCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      issueCnt_q    <= '0;
      respCnt_q     <= '0;
      outstanding_q <= '0;
      seed_q        <= '0;
      errCnt_q      <= '0;
    end else begin
      issueCnt_q    <= issueCnt_d;
      respCnt_q     <= respCnt_d;
      outstanding_q <= outstanding_d;
      seed_q        <= seed_d;
      errCnt_q      <= errCnt_d;
    end
  end

  assign error_count_o = errCnt_q;

`ifdef BP_MEM_TRAFFIC_GEN_TRACE_EN
  always @(posedge clk_i) begin
    if (!reset_i && mem_cmd_v_o)
      $display("%0t tg cmd   phase=%s addr=%h", $time, state_q.name(), cmdMsg.header.addr);
    if (!reset_i && mem_resp_v_i) begin
      if (errInc)
        $display("%0t tg resp  phase=%s addr=%h bad exp=%h act=%h", $time, state_q.name(),
                 respMsg.header.addr, checkPattern, respMsg.data);
      else
        $display("%0t tg resp  phase=%s addr=%h ok", $time, state_q.name(), respMsg.header.addr);
    end
  end
`else
`endif

endmodule

// File: tb/tb_bp_mem_traffic_gen.sv
// Directed bench for bp_mem_traffic_gen against a small in-order memory responder model.
module tb_bp_mem_traffic_gen;
  import bp_mem_traffic_gen_pkg::*;

  localparam logic [39:0] baseAddr = 40'h00_8000_0000;
  localparam int numBlocks = 16;
  localparam int maxOut    = 4;
  localparam int errWidth  = 16;

  logic clock, reset, startIn, memCmdV, memCmdReady, memRespV, memRespYumi, busy, done;
  logic [15:0] seedIn;
  logic [cce_mem_msg_width_lp-1:0] memCmd, memResp;
  logic [errWidth-1:0] errorCount;

  typedef struct packed {
    logic                   spur;
    bp_bedrock_mem_type_e   msgType;
    logic [39:0]            addr;
    logic [511:0]           data;
  } respEntry_t;

  respEntry_t respQ[$];
  logic [511:0] memory [numBlocks];
  logic [39:0] wrAddrs[$];
  bp_bedrock_cce_mem_header_s firstWrHdr;
  int wrCount, rdCount, inflight, peakInflight, yumiMiss, rdDataNonZero, holdUntil;
  int cycle = 0;
  bit flipRead3, spurReq;
  int checks = 0;
  int errors = 0;

  bp_mem_traffic_gen #(
    .base_addr_p      (baseAddr),
    .num_blocks_p     (numBlocks),
    .max_outstanding_p(maxOut),
    .err_width_p      (errWidth)
  ) dut (
    .clk_i          (clock),
    .reset_i        (reset),
    .start_i        (startIn),
    .seed_i         (seedIn),
    .mem_cmd_o      (memCmd),
    .mem_cmd_v_o    (memCmdV),
    .mem_cmd_ready_i(memCmdReady),
    .mem_resp_i     (memResp),
    .mem_resp_v_i   (memRespV),
    .mem_resp_yumi_o(memRespYumi),
    .busy_o         (busy),
    .done_o         (done),
    .error_count_o  (errorCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] seed);
    @(posedge clock); #1;
    startIn = 1'b1;
    seedIn  = seed;
    @(posedge clock); #1;
    startIn = 1'b0;
  endtask

  task automatic clearRun();
    wrAddrs.delete();
    wrCount = 0; rdCount = 0; inflight = 0; peakInflight = 0; rdDataNonZero = 0;
  endtask

  task automatic waitDone(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clock);
      if (done) break;
    end
    checkOutput("doneReached", done, 1);
  endtask

  // Responder: samples commands/handshakes on the falling edge, updates the response
  // it presents just after the rising edge; responses come back strictly in order.
  initial begin : responder
    bp_bedrock_cce_mem_msg_s cmdMsg, respMsg;
    respEntry_t e;
    bit cmdFire, respFire;
    int blk;
    memRespV = 1'b0;
    memResp  = '0;
    forever begin
      @(negedge clock);
      cmdFire  = memCmdV;
      cmdMsg   = memCmd;
      respFire = memRespV;
      if (respFire && !memRespYumi) yumiMiss++;
      if (respFire && respQ.size() > 0 && !respQ[0].spur && inflight > 0) inflight--;
      if (cmdFire) begin
        blk       = int'((cmdMsg.header.addr - baseAddr) >> 6);
        e.spur    = 1'b0;
        e.msgType = cmdMsg.header.msg_type;
        e.addr    = cmdMsg.header.addr;
        e.data    = '0;
        if (cmdMsg.header.msg_type == e_bedrock_mem_uc_wr) begin
          if (wrAddrs.size() == 0) firstWrHdr = cmdMsg.header;
          wrCount++;
          wrAddrs.push_back(cmdMsg.header.addr);
          if (blk >= 0 && blk < numBlocks) memory[blk] = cmdMsg.data;
        end else begin
          rdCount++;
          if (cmdMsg.data != '0) rdDataNonZero++;
          if (blk >= 0 && blk < numBlocks) e.data = memory[blk];
          if (flipRead3 && blk == 3) e.data[0] = ~e.data[0];
        end
        respQ.push_back(e);
        inflight++;
        if (inflight > peakInflight) peakInflight = inflight;
      end
      @(posedge clock); #1;
      if (respFire && respQ.size() > 0) void'(respQ.pop_front());
      if (spurReq) begin
        e.spur    = 1'b1;
        e.msgType = e_bedrock_mem_uc_rd;
        e.addr    = baseAddr;
        e.data    = '0;
        respQ.push_back(e);
        spurReq = 1'b0;
      end
      respMsg = '0;
      if (respQ.size() > 0) begin
        respMsg.header.msg_type = respQ[0].msgType;
        respMsg.header.addr     = respQ[0].addr;
        respMsg.header.size     = e_bedrock_msg_size_64;
        respMsg.data            = respQ[0].data;
      end
      memResp  = respMsg;
      memRespV = (respQ.size() > 0) && (cycle >= holdUntil);
    end
  end

  // Main sequence: reset, idle spurious response, clean run, corrupted read,
  // stalled responder, ready back-pressure, reset mid-read and rerun.
  initial begin : mainSeq
    int nBefore, vHigh;
    reset = 1'b1; startIn = 1'b0; seedIn = '0; memCmdReady = 1'b1;
    holdUntil = 0; flipRead3 = 1'b0; spurReq = 1'b0; yumiMiss = 0;
    clearRun();
    repeat (2) @(posedge clock); #1;
    checkOutput("rstCmdV", memCmdV, 0);
    checkOutput("rstYumi", memRespYumi, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", errorCount, 0);
    reset = 1'b0;

    @(posedge clock); #1;
    spurReq = 1'b1;
    repeat (4) @(posedge clock); #1;
    checkOutput("idleSpurErr", errorCount, 1);
    checkOutput("idleSpurYumi", yumiMiss, 0);
    checkOutput("idleBusy", busy, 0);

    clearRun();
    applyStimulus(16'hA5A5);
    checkOutput("startClrErr", errorCount, 0);
    checkOutput("startBusy", busy, 1);
    checkOutput("startDone", done, 0);
    waitDone(2000);
    checkOutput("cleanErr", errorCount, 0);
    checkOutput("cleanBusy", busy, 0);
    checkOutput("wrCount", wrCount, 16);
    checkOutput("rdCount", rdCount, 16);
    checkOutput("firstWrAddr", firstWrHdr.addr, 40'h00_8000_0000);
    checkOutput("firstWrType", firstWrHdr.msg_type, 3);
    checkOutput("firstWrSize", firstWrHdr.size, 6);
    checkOutput("firstWrPayload", firstWrHdr.payload, 0);
    checkOutput("lastWrAddr", wrAddrs[15], 40'h00_8000_03C0);
    checkOutput("blk0Word0", memory[0][31:0], 32'hA5A5_0000);
    checkOutput("blk15TopWord", memory[15][511:480], 32'hA5A5_000F);
    checkOutput("rdCmdData", rdDataNonZero, 0);

    clearRun();
    flipRead3 = 1'b1;
    applyStimulus(16'h5A5A);
    waitDone(2000);
    flipRead3 = 1'b0;
    checkOutput("flipErr", errorCount, 1);
    checkOutput("flipBlk3", memory[3][31:0], 32'h5A5A_0003);

    clearRun();
    applyStimulus(16'h0F0F);
    holdUntil = cycle + 20;
    waitDone(2000);
    checkOutput("stallPeak", peakInflight, 4);
    checkOutput("stallErr", errorCount, 0);

    clearRun();
    applyStimulus(16'h3C3C);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (wrCount >= 5) break;
    end
    @(posedge clock); #1;
    memCmdReady = 1'b0;
    @(negedge clock);
    nBefore = wrCount;
    vHigh = 0;
    repeat (50) begin
      @(negedge clock);
      if (memCmdV) vHigh++;
    end
    checkOutput("readyLowV", vHigh, 0);
    checkOutput("readyLowBusy", busy, 1);
    @(posedge clock); #1;
    memCmdReady = 1'b1;
    waitDone(2000);
    checkOutput("resumeWrCount", wrCount, 16);
    if (wrAddrs.size() > nBefore)
      checkOutput("resumeAddr", wrAddrs[nBefore], baseAddr + 40'(nBefore * 64));
    else
      checkOutput("resumeAddrMissing", wrAddrs.size(), nBefore + 1);
    checkOutput("resumeErr", errorCount, 0);

    clearRun();
    applyStimulus(16'hBEEF);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (rdCount >= 4) break;
    end
    checkOutput("midReadBusy", busy, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetCmdV", memCmdV, 0);
    checkOutput("resetErr", errorCount, 0);
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    repeat (10) @(posedge clock); #1;
    checkOutput("postResetDone", done, 0);
    clearRun();
    applyStimulus(16'h1234);
    waitDone(2000);
    checkOutput("rerunErr", errorCount, 0);
    checkOutput("rerunBlk2", memory[2][31:0], 32'h1234_0002);
    checkOutput("rerunRdCount", rdCount, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
